// File: rtl/vector_max_seq_if.sv
// Bundle between the vector_max sequencer, its control FSM, the vector buffer
// and the shared vector_max unit.
interface vector_max_seq_if #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 6
);
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [ADDR_W:0]      len;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [4*WIDTH-1:0]   mem_rdata;
    logic                 vm_start;
    logic [4*WIDTH-1:0]   vm_vec;
    logic [WIDTH-1:0]     vm_max;
    logic                 vm_done;
    logic [WIDTH-1:0]     max_out;
    logic [ADDR_W-1:0]    idx_out;
    logic                 done;
    logic                 busy;
    logic                 timeout_err;

    // Environment side: controller, buffer and vector_max unit.
    modport master (
        output start, base_addr, len, mem_rdata, vm_max, vm_done,
        input  mem_rd_en, mem_addr, vm_start, vm_vec, max_out, idx_out,
               done, busy, timeout_err
    );

    // Sequencer side.
    modport slave (
        input  start, base_addr, len, mem_rdata, vm_max, vm_done,
        output mem_rd_en, mem_addr, vm_start, vm_vec, max_out, idx_out,
               done, busy, timeout_err
    );
endinterface

// File: rtl/vector_max_seq.sv
// Walks LEN buffered vectors through one shared vector_max unit and tracks the
// running maximum and the index of the first vector that produced it.
module vector_max_seq #(
    parameter int WIDTH   = 12,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              reset,
    vector_max_seq_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [TW-1:0]     tcnt;

    assign cnt_nxt = cnt + 1'b1;

    // All outputs are registered; strobes are set on the edge entering their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            base_r          <= '0;
            len_r           <= '0;
            cnt             <= '0;
            tcnt            <= '0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.vm_start    <= 1'b0;
            bus.vm_vec      <= '0;
            bus.max_out     <= '0;
            bus.idx_out     <= '0;
            bus.done        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.mem_rd_en <= 1'b0;
            bus.vm_start  <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        base_r          <= bus.base_addr;
                        len_r           <= bus.len;
                        cnt             <= '0;
                        bus.timeout_err <= 1'b0;
                        bus.busy        <= 1'b1;
                        if (bus.len == '0) begin
                            state <= S_DONE;
                        end else begin
                            state         <= S_FETCH;
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= bus.base_addr;
                        end
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    bus.vm_vec   <= bus.mem_rdata;
                    bus.vm_start <= 1'b1;
                    state        <= S_ISSUE;
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.vm_done) begin
                        // Strict compare keeps the earliest index on ties.
                        if (cnt == '0 || bus.vm_max > bus.max_out) begin
                            bus.max_out <= bus.vm_max;
                            bus.idx_out <= cnt[ADDR_W-1:0];
                        end
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len_r) begin
                            state <= S_DONE;
                        end else begin
                            state         <= S_FETCH;
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= base_r + cnt_nxt[ADDR_W-1:0];
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        bus.timeout_err <= 1'b1;
                        state           <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/vector_max_seq.md
Name: vector_max_seq

Overview:
Sequencer that drives one shared vector_max unit (4 lanes × WIDTH, 2-cycle start→done) across a block of packed vectors held in a synchronous-read buffer.
- Fetches LEN vectors starting at BASE_ADDR and issues each one to the unit.
- Keeps a running maximum and the index of the vector that produced it (argmax).
- Reports the result with a one-cycle done pulse.
- Sits between the control FSM (start/done handshake) and the vector_max instance plus its vector buffer.

Parameters:
WIDTH, 12, lane width in bits; must match the vector_max instance
ADDR_W, 6, vector buffer address width; up to 2^ADDR_W vectors per run
TIMEOUT, 15, max cycles in WAIT before the vector_max response is declared lost

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  run request; sampled only in IDLE
base_addr  input  ADDR_W  first vector address; captured on accepted start
len  input  ADDR_W+1  number of vectors, 0..2^ADDR_W; captured on accepted start
mem_rd_en  output  1  buffer read strobe
mem_addr  output  ADDR_W  buffer read address
mem_rdata  input  4*WIDTH  buffer data; valid the cycle after mem_rd_en
vm_start  output  1  start pulse to vector_max
vm_vec  output  4*WIDTH  vector to vector_max; held stable from vm_start until vm_done
vm_max  input  WIDTH  max_out from vector_max
vm_done  input  1  done from vector_max
max_out  output  WIDTH  run maximum
idx_out  output  ADDR_W  offset (0..len-1) of the first vector holding the maximum
done  output  1  one-cycle pulse, result valid
busy  output  1  high in every state except IDLE
timeout_err  output  1  sticky; set on WAIT timeout, cleared by the next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE. Outputs mem_rd_en, vm_start, done, busy, timeout_err = 0. Registers max_out, idx_out, mem_addr, vm_vec, counters = 0. Reset in any state aborts the run on the next edge, with no done pulse.
- States:
  - IDLE: start=1 → capture base_addr/len, clear timeout_err. If len==0 → DONE, else → FETCH.
  - FETCH: mem_rd_en=1, mem_addr=base_addr+cnt (mod 2^ADDR_W) → LOAD.
  - LOAD: vm_vec <= mem_rdata → ISSUE.
  - ISSUE: vm_start=1 for exactly this cycle → WAIT. Clear the timeout counter.
  - WAIT: vm_vec held. On vm_done=1:
    - If cnt==0 or vm_max > max_out (unsigned, strict): max_out<=vm_max, idx_out<=cnt.
    - cnt<=cnt+1. If cnt+1==len → DONE, else → FETCH.
    - If the timeout counter reaches TIMEOUT without vm_done: timeout_err<=1 → DONE, keeping the partial result.
  - DONE: done=1 for one cycle → IDLE.
- Per-vector latency with a nominal vector_max: 5 cycles (FETCH, LOAD, ISSUE, WAIT×2). Run latency from start to done = 1 + 5·len + 1 cycles.
  - len=0: done 2 cycles after start, max_out=0, idx_out=0.
- Ties: the strict > comparison means the earliest index wins.
- start while busy: ignored; no effect on the current run.
- vm_done outside WAIT: ignored.
- vm_start is never asserted while a prior issue is outstanding.
- max_out/idx_out hold their values after done until the next accepted start with len≥1 writes them. The first vector always overwrites the stale value.
- Address wrap: base_addr+cnt wraps modulo 2^ADDR_W.
- len=2^ADDR_W reads every entry exactly once. cnt is ADDR_W+1 bits wide.

Test Plan:
- Basic run: base=0, len=3. Buffer[0]={1,2,3,4}, [1]={0,0,0xA00,5}, [2]={7,7,7,7}. Required: done 17 cycles after start, max_out=0xA00, idx_out=1, exactly 3 vm_start pulses.
- Tie and wrap: ADDR_W=6, base=63, len=2. Buffer[63]={9,0,0,0}, [0]={0,9,0,0}. Required: mem_addr sequence 63, 0; max_out=9, idx_out=0.
- len=0: start → done 2 cycles later, max_out=0, idx_out=0, no mem_rd_en or vm_start.
- Timeout: vector_max model suppresses vm_done on vector 1 of len=3. Required: timeout_err=1 and done TIMEOUT+1 cycles after WAIT entry, with max_out/idx_out reflecting vector 0. A following start clears timeout_err.
- start during busy: pulse start again mid-run with a different len. Required: the run completes with the original len, and only one done pulse.
- Reset mid-run: assert reset during WAIT of vector 1. Required: next cycle state IDLE, busy=0, max_out=0, no done. A fresh run afterwards produces correct results.
